byte_mem_ctrl: RTL and testbench
================================

# byte_mem_ctrl

Parametrised, synchronous, byte-addressable memory with a valid/ready request/response handshake, big-endian (SPARC) byte ordering and byte/halfword/word access sizes. It is the clocked successor to the unclocked 8-bit RAM and serves as instruction or data memory behind the processor's fetch and load/store paths. Programmable wait states emulate slower memory. Misaligned or out-of-range accesses return an error instead of corrupting memory.

## Interface
- DEPTH, 512: size in bytes; must be a power of two, at least 4.
- ADDR_W, $clog2(DEPTH): byte-address width.
- WAIT_STATES, 0: extra cycles inserted between request acceptance and response (0–15).
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (error).
- req_signed  input  1  sign-extend load data (byte/halfword only).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  32  load data, right-justified and extended; 0 for stores and errors.
- rsp_error  output  1  access was misaligned, out of range, or used a reserved size.

## Operation
- FSM states:
  - IDLE: req_ready=1. On req_valid, capture write, size, signed, addr and wdata. Go to WAIT if WAIT_STATES>0, otherwise COMMIT.
  - WAIT: a down-counter loaded with WAIT_STATES-1 decrements each cycle. At 0, go to COMMIT.
  - COMMIT: one cycle. Perform the array access and register rdata/error. Go to RESP.
  - RESP: rsp_valid=1. Hold rsp_rdata and rsp_error stable until rsp_ready=1, then go to IDLE.
- Error checks, evaluated on the captured request:
  - Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
  - Range: addr+bytes-1 < DEPTH, and addr[31:ADDR_W] must be 0.
  - size=11 is always an error.
  - On error, no bytes are written and rsp_rdata=0.
- Byte ordering is big-endian. Word at A: Mem[A]=wdata[31:24], Mem[A+1]=[23:16], Mem[A+2]=[15:8], Mem[A+3]=[7:0].
- Halfword at A: Mem[A]=wdata[15:8], Mem[A+1]=wdata[7:0]. Byte: Mem[A]=wdata[7:0].
- Load extension: byte/halfword are zero-extended to 32 bits, or sign-extended when req_signed=1. req_signed is ignored for word loads.
- Memory contents are not reset and are X until written. The bench preloads via hierarchical $readmemh.

## Timing
- Reset values while rst_n=0 at a clock edge: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, wait counter=0.
- Latency from the accepting edge to rsp_valid high is 2+WAIT_STATES cycles. With WAIT_STATES=0: accept at edge N, commit at N+1, rsp_valid at N+2.
- Stores become visible at the COMMIT edge. A load issued after that store's response reads the new data.
- req_ready is low outside IDLE. There is no overlap, so peak throughput is one access per 3+WAIT_STATES cycles.
- If rsp_ready is high on the first RESP cycle, the response lasts exactly one cycle and req_ready returns the next cycle.
- If rsp_ready stays low, RESP is held indefinitely with outputs frozen.
- req_* inputs are don't-care outside IDLE; only captured values are used.
- Reset during WAIT aborts the access with no memory change. Reset during COMMIT still lets that edge's write land (the write and reset share the edge), and all outputs clear. Reset during RESP drops the response.

## Structure
- Package byte_mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - state enum IDLE, WAIT, COMMIT, RESP;
  - function access_ok(size, addr) for alignment and range checks.
- Sub-module byte_mem_array: DEPTH×8 storage with four byte-lane write enables and a synchronous 4-byte read at a word-aligned base. The controller handles lane steering, extension, FSM and wait counter.

## Test plan
- Word store 0xDEADBEEF to 0x010, then byte loads at 0x010..0x013 -> responses 0xDE, 0xAD, 0xBE, 0xEF, all with rsp_error=0.
- Signed halfword load at 0x012 -> 0xFFFFBEEF. Unsigned halfword load at 0x012 -> 0x0000BEEF. Signed byte load at 0x011 -> 0xFFFFFFAD.
- Misaligned word store of 0x12345678 to 0x021 -> rsp_error=1, rsp_rdata=0; a word load at 0x020 still returns its prior contents. Word load at 0x1FE -> error. Byte load at 0x200 -> error. size=11 -> error.
- WAIT_STATES=3: accept at edge N -> rsp_valid rises at N+5. Hold rsp_ready=0 for 4 cycles -> rsp_valid and rsp_rdata stay constant and req_ready stays 0.
- Back-to-back loads with rsp_ready tied high and WAIT_STATES=0 -> each response lasts one cycle, with one access per 3 cycles.
- Assert rst_n=0 during WAIT of a store of 0xCAFEF00D to 0x040 -> after reset, a word load at 0x040 returns the original data, and all outputs read their reset values at the reset edge.

Source files
------------

// File: rtl/byte_mem_pkg.sv
// -----------------------------------------------------------------------------
// byte_mem_pkg
//
// Shared definitions for the byte-addressable memory controller:
//   - access size encodings carried on req_size
//   - controller FSM state enumeration
//   - access_ok(): alignment and range check for one captured request
//
// No ports; imported by byte_mem_ctrl.
// -----------------------------------------------------------------------------
package byte_mem_pkg;

    // Access size encodings as they arrive on req_size.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Controller states. A request always walks IDLE -> (WAIT) -> COMMIT -> RESP.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Returns 1 when an access of the given size at the given byte address is
    // naturally aligned and every byte it touches lies inside a memory of
    // 'depth' bytes. The last-byte address is formed in 33 bits so that
    // addresses near 2^32 cannot wrap around and look in range; that same
    // comparison also rejects any address with bits set above the array width.
    function automatic logic access_ok(
        input logic [1:0]  size,
        input logic [31:0] addr,
        input logic [32:0] depth
    );
        logic [32:0] last_byte;
        logic        aligned;

        last_byte = {1'b0, addr};
        aligned   = 1'b1;
        case (size)
            SZ_BYTE: begin
                aligned   = 1'b1;
                last_byte = {1'b0, addr};
            end
            SZ_HALF: begin
                aligned   = ~addr[0];
                last_byte = {1'b0, addr} + 33'd1;
            end
            SZ_WORD: begin
                aligned   = (addr[1:0] == 2'b00);
                last_byte = {1'b0, addr} + 33'd3;
            end
            default: begin
                aligned   = 1'b0;
                last_byte = {1'b0, addr};
            end
        endcase
        return aligned && (last_byte < depth);
    endfunction

endpackage

// File: rtl/byte_mem_array.sv
// -----------------------------------------------------------------------------
// byte_mem_array
//
// DEPTH x 8 storage organised as word-wide rows of four byte lanes.
// Lane k holds the byte at (word base + k); lane 0 sits in bits [31:24] so a
// full-lane read is already in big-endian order.
//
// Ports:
//   clk    in   clock
//   addr   in   byte address; the low two bits are ignored (word base used)
//   we     in   per-lane write enables, bit k = lane k
//   wdata  in   lane data, lane k in bits [31-8k -: 8]
//   re     in   read enable; rdata updates only when high
//   rdata  out  registered 4-byte read of the addressed word
//
// Contents are not reset.
// -----------------------------------------------------------------------------
module byte_mem_array #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        we,
    input  logic [31:0]       wdata,
    input  logic              re,
    output logic [31:0]       rdata
);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] base;

    // Word-aligned base; masking rather than slicing keeps this legal for the
    // smallest 4-byte array where there are no address bits above bit 1.
    assign base = addr & ~ADDR_W'(3);

    // Lane writes and the registered read share one edge. A read that lands
    // on the same edge as a write returns the old contents, which never
    // matters here because the controller reads and writes in separate
    // requests.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we[k]) begin
                mem[base + ADDR_W'(k)] <= wdata[31 - 8*k -: 8];
            end
        end
        if (re) begin
            rdata <= {mem[base],
                      mem[base + ADDR_W'(1)],
                      mem[base + ADDR_W'(2)],
                      mem[base + ADDR_W'(3)]};
        end
    end

endmodule

// File: rtl/byte_mem_ctrl.sv
// -----------------------------------------------------------------------------
// byte_mem_ctrl
//
// Synchronous byte-addressable memory with a valid/ready request/response
// handshake, big-endian byte order and byte/halfword/word accesses.
// Misaligned, out-of-range or reserved-size accesses answer with rsp_error
// and leave memory untouched. WAIT_STATES extra cycles may be inserted
// between accepting a request and performing it, to mimic slow memory.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   req_valid   in   request present
//   req_ready   out  high only while idle
//   req_write   in   1 = store, 0 = load
//   req_size    in   00 byte, 01 halfword, 10 word, 11 reserved
//   req_signed  in   sign-extend byte/halfword loads
//   req_addr    in   byte address
//   req_wdata   in   store data, right-justified
//   rsp_valid   out  response present
//   rsp_ready   in   consumer takes the response
//   rsp_rdata   out  load data, right-justified and extended; 0 otherwise
//   rsp_error   out  request was rejected
// -----------------------------------------------------------------------------
module byte_mem_ctrl #(
    parameter int DEPTH       = 512,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    import byte_mem_pkg::*;

    // Value loaded into the wait counter on acceptance; the counter then
    // spends exactly WAIT_STATES cycles in WAIT before reaching zero.
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      state;
    state_t      next_state;
    logic [3:0]  wait_cnt;
    logic        accept;

    logic        cap_write;
    logic [1:0]  cap_size;
    logic        cap_signed;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic        access_good;
    logic        err_q;
    logic [1:0]  offset;

    logic [3:0]  lane_we;
    logic [31:0] lane_wdata;
    logic        mem_re;
    logic [31:0] mem_rdata;

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    assign accept      = (state == IDLE) && req_valid;
    assign access_good = access_ok(cap_size, cap_addr, 33'(DEPTH));
    assign offset      = cap_addr[1:0];

    // State register. Reset always returns to IDLE, which abandons any
    // access still waiting and drops any response not yet taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. With no wait states the WAIT state is skipped and a
    // request goes straight from IDLE to COMMIT. RESP is held until the
    // consumer accepts the response.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    next_state = (WAIT_STATES > 0) ? WAIT : COMMIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = COMMIT;
                end
            end
            COMMIT: begin
                next_state = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output logic. The response fields are forced to zero outside RESP so
    // that nothing stale from an earlier access shows through, and load data
    // is suppressed for stores and rejected requests.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_error = 1'b0;
        rsp_rdata = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_error = err_q;
                if (!err_q && !cap_write) begin
                    rsp_rdata = load_data;
                end
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // Wait-state down-counter: loaded when a request is accepted and counted
    // down while in WAIT. It rests at zero outside WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (accept && (WAIT_STATES > 0)) begin
            wait_cnt <= WS_LOAD;
        end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Request capture. Only the values present on the accepting edge are
    // used; the request inputs are ignored for the rest of the access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_write  <= 1'b0;
            cap_size   <= SZ_BYTE;
            cap_signed <= 1'b0;
            cap_addr   <= 32'h0;
            cap_wdata  <= 32'h0;
        end else if (accept) begin
            cap_write  <= req_write;
            cap_size   <= req_size;
            cap_signed <= req_signed;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
        end
    end

    // Error flag, decided once in COMMIT and held through RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state == COMMIT) begin
            err_q <= ~access_good;
        end
    end

    // Store lane steering. The store data is replicated across the lanes so
    // that whichever lanes are enabled see the right bytes: a halfword at
    // offset 2 picks up {hi, lo} from lanes 2 and 3, a byte at offset k from
    // lane k. Enables are only raised during COMMIT of a good store; they are
    // deliberately not gated by reset so a store committing on a reset edge
    // still lands.
    always_comb begin
        lane_we    = 4'b0000;
        lane_wdata = cap_wdata;
        case (cap_size)
            SZ_BYTE: begin
                lane_wdata = {4{cap_wdata[7:0]}};
                lane_we    = 4'b0001 << offset;
            end
            SZ_HALF: begin
                lane_wdata = {2{cap_wdata[15:0]}};
                lane_we    = offset[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                lane_wdata = cap_wdata;
                lane_we    = 4'b1111;
            end
            default: begin
                lane_we    = 4'b0000;
            end
        endcase
        if (!((state == COMMIT) && cap_write && access_good)) begin
            lane_we = 4'b0000;
        end
    end

    // The array read is registered on the COMMIT edge and then stays put for
    // as long as RESP lasts, which is what keeps rsp_rdata stable under
    // back-pressure.
    assign mem_re = (state == COMMIT) && !cap_write && access_good;

    byte_mem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .addr  (cap_addr[ADDR_W-1:0]),
        .we    (lane_we),
        .wdata (lane_wdata),
        .re    (mem_re),
        .rdata (mem_rdata)
    );

    // Load extraction: pick the addressed byte or halfword out of the word
    // just read, then zero- or sign-extend it. Word loads ignore cap_signed.
    always_comb begin
        case (offset)
            2'd0:    load_byte = mem_rdata[31:24];
            2'd1:    load_byte = mem_rdata[23:16];
            2'd2:    load_byte = mem_rdata[15:8];
            default: load_byte = mem_rdata[7:0];
        endcase
        load_half = offset[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        load_data = 32'h0;
        case (cap_size)
            SZ_BYTE: load_data = {{24{cap_signed & load_byte[7]}}, load_byte};
            SZ_HALF: load_data = {{16{cap_signed & load_half[15]}}, load_half};
            SZ_WORD: load_data = mem_rdata;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_byte_mem_ctrl
//
// Two controllers share clock and reset: instance 0 has no wait states,
// instance 1 has three. A byte-array model in the bench predicts every
// response from the access rules; a negedge process compares the DUT against
// it on every cycle, and directed sequences pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_byte_mem_ctrl;

    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic rst_n;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_write;
    logic [1:0][1:0]  req_size;
    logic [1:0]       req_signed;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][31:0] rsp_rdata;
    logic [1:0]       rsp_error;

    // Reference model state
    logic [7:0]       ref_mem [2][DEPTH];
    bit   [1:0]       exp_pending;
    logic [1:0][31:0] exp_rdata;
    logic [1:0]       exp_err;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    byte_mem_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_write  (req_write[0]),
        .req_size   (req_size[0]),
        .req_signed (req_signed[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .rsp_valid  (rsp_valid[0]),
        .rsp_ready  (rsp_ready[0]),
        .rsp_rdata  (rsp_rdata[0]),
        .rsp_error  (rsp_error[0])
    );

    byte_mem_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_write  (req_write[1]),
        .req_size   (req_size[1]),
        .req_signed (req_signed[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .rsp_valid  (rsp_valid[1]),
        .rsp_ready  (rsp_ready[1]),
        .rsp_rdata  (rsp_rdata[1]),
        .rsp_error  (rsp_error[1])
    );

    function automatic int ws(input int idx);
        return (idx == 0) ? 0 : 3;
    endfunction

    // Behavioural model: size in bytes, natural alignment, bounds, then a
    // plain big-endian byte loop for the data.
    function automatic void model_access(input int idx, input logic wr, input logic [1:0] sz,
                                         input logic sg, input logic [31:0] ad, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic er);
        int     n;
        longint last;
        n    = (sz == 2'd3) ? 4 : (1 << sz);
        last = longint'(ad) + longint'(n) - 1;
        er   = (sz == 2'd3) || ((ad % n) != 0) || (last >= DEPTH);
        rd   = 32'h0;
        if (!er) begin
            if (wr) begin
                for (int i = 0; i < n; i++) ref_mem[idx][ad + i] = wd[8*(n-1-i) +: 8];
            end else begin
                for (int i = 0; i < n; i++) rd = (rd << 8) | 32'(ref_mem[idx][ad + i]);
                if (sg && (n < 4) && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkReset();
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_req_ready", 32'(req_ready[i]), 32'd1);
            checkOutput("reset_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            checkOutput("reset_rsp_rdata", rsp_rdata[i],      32'd0);
            checkOutput("reset_rsp_error", 32'(rsp_error[i]), 32'd0);
        end
    endtask

    // One complete access. Called and returns #1 after a rising edge.
    // hold = number of RESP cycles with rsp_ready low before taking it.
    task automatic applyStimulus(input int idx, input logic wr, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] ad, input logic [31:0] wd, input int hold,
                                 output logic [31:0] got_rd, output logic got_er, output int acc_cycle);
        logic [31:0] er_rd;
        logic        er_er;
        int          guard;
        int          lat;
        got_rd    = 32'h0;
        got_er    = 1'b0;
        acc_cycle = 0;
        guard     = 0;
        while (req_ready[idx] !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (req_ready[idx] !== 1'b1) begin
            checkOutput("ready_timeout", 32'(req_ready[idx]), 32'd1);
            return;
        end
        model_access(idx, wr, sz, sg, ad, wd, er_rd, er_er);
        req_valid[idx]  = 1'b1;
        req_write[idx]  = wr;
        req_size[idx]   = sz;
        req_signed[idx] = sg;
        req_addr[idx]   = ad;
        req_wdata[idx]  = wd;
        rsp_ready[idx]  = (hold == 0);
        @(posedge clk); #1;
        acc_cycle        = cycle;
        exp_pending[idx] = 1'b1;
        exp_rdata[idx]   = er_rd;
        exp_err[idx]     = er_er;
        // Request fields are don't-care once accepted
        req_valid[idx]  = 1'b0;
        req_write[idx]  = 1'($urandom);
        req_size[idx]   = 2'($urandom);
        req_signed[idx] = 1'($urandom);
        req_addr[idx]   = $urandom;
        req_wdata[idx]  = $urandom;
        lat = 0;
        while (rsp_valid[idx] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (rsp_valid[idx] !== 1'b1) begin
            checkOutput("rsp_timeout", 32'(rsp_valid[idx]), 32'd1);
            exp_pending[idx] = 1'b0;
            return;
        end
        checkOutput("latency", 32'(lat + 1), 32'(2 + ws(idx)));
        got_rd = rsp_rdata[idx];
        got_er = rsp_error[idx];
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                checkOutput("hold_valid", 32'(rsp_valid[idx]), 32'd1);
                checkOutput("hold_rdata", rsp_rdata[idx], got_rd);
                checkOutput("hold_ready", 32'(req_ready[idx]), 32'd0);
            end
            rsp_ready[idx] = 1'b1;
        end
        @(posedge clk); #1;
        checkOutput("rsp_one_cycle", 32'(rsp_valid[idx]), 32'd0);
        checkOutput("ready_after_rsp", 32'(req_ready[idx]), 32'd1);
    endtask

    // Cycle-by-cycle compare against the model's outstanding response.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                if (exp_pending[i]) begin
                    checkOutput("busy_req_ready", 32'(req_ready[i]), 32'd0);
                    if (rsp_valid[i] === 1'b1) begin
                        checkOutput("rsp_rdata", rsp_rdata[i], exp_rdata[i]);
                        checkOutput("rsp_error", 32'(rsp_error[i]), 32'(exp_err[i]));
                        if (rsp_ready[i]) exp_pending[i] = 1'b0;
                    end
                end else begin
                    checkOutput("idle_req_ready", 32'(req_ready[i]), 32'd1);
                    checkOutput("idle_rsp_valid", 32'(rsp_valid[i]), 32'd0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          ac;
        int          prev;
        logic [1:0]  sz;
        logic [31:0] ad;

        rst_n       = 1'b0;
        req_valid   = '0;
        req_write   = '0;
        req_size    = '0;
        req_signed  = '0;
        req_addr    = '0;
        req_wdata   = '0;
        rsp_ready   = '0;
        exp_pending = '0;
        exp_rdata   = '0;
        exp_err     = '0;
        repeat (3) @(posedge clk);
        #1;
        checkReset();
        rst_n = 1'b1;

        // Fill both memories with known random words
        for (int idx = 0; idx < 2; idx++)
            for (int w = 0; w < DEPTH/4; w++)
                applyStimulus(idx, 1'b1, 2'd2, 1'b0, 32'(w*4), $urandom, 0, rd, er, ac);

        // Big-endian word store, byte loads
        applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 0, rd, er, ac);
        checkOutput("store_err", 32'(er), 32'd0);
        applyStimulus(0, 1'b0, 2'd0, 1'b0, 32'h010, 32'h0, 0, rd, er, ac);
        checkOutput("byte10", rd, 32'h000000DE);
        applyStimulus(0, 1'b0, 2'd0, 1'b0, 32'h011, 32'h0, 0, rd, er, ac);
        checkOutput("byte11", rd, 32'h000000AD);
        applyStimulus(0, 1'b0, 2'd0, 1'b0, 32'h012, 32'h0, 0, rd, er, ac);
        checkOutput("byte12", rd, 32'h000000BE);
        applyStimulus(0, 1'b0, 2'd0, 1'b0, 32'h013, 32'h0, 0, rd, er, ac);
        checkOutput("byte13", rd, 32'h000000EF);
        checkOutput("byte13_err", 32'(er), 32'd0);

        // Extension
        applyStimulus(0, 1'b0, 2'd1, 1'b1, 32'h012, 32'h0, 0, rd, er, ac);
        checkOutput("shalf12", rd, 32'hFFFFBEEF);
        applyStimulus(0, 1'b0, 2'd1, 1'b0, 32'h012, 32'h0, 0, rd, er, ac);
        checkOutput("uhalf12", rd, 32'h0000BEEF);
        applyStimulus(0, 1'b0, 2'd0, 1'b1, 32'h011, 32'h0, 0, rd, er, ac);
        checkOutput("sbyte11", rd, 32'hFFFFFFAD);

        // Errors leave memory untouched
        applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'h020, 32'h01020304, 0, rd, er, ac);
        applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'h021, 32'h12345678, 0, rd, er, ac);
        checkOutput("misalign_err", 32'(er), 32'd1);
        checkOutput("misalign_rdata", rd, 32'h0);
        applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h020, 32'h0, 0, rd, er, ac);
        checkOutput("word20_kept", rd, 32'h01020304);
        applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h1FE, 32'h0, 0, rd, er, ac);
        checkOutput("word1fe_err", 32'(er), 32'd1);
        applyStimulus(0, 1'b0, 2'd0, 1'b0, 32'h200, 32'h0, 0, rd, er, ac);
        checkOutput("byte200_err", 32'(er), 32'd1);
        applyStimulus(0, 1'b0, 2'd3, 1'b0, 32'h000, 32'h0, 0, rd, er, ac);
        checkOutput("rsvd_err", 32'(er), 32'd1);
        checkOutput("rsvd_rdata", rd, 32'h0);

        // Back-to-back loads: one access every three cycles
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'(4 * $urandom_range(0, 127)), 32'h0, 0, rd, er, ac);
            if (k > 0) checkOutput("b2b_spacing", 32'(ac - prev), 32'd3);
            prev = ac;
        end

        // Wait states with back-pressure
        applyStimulus(1, 1'b1, 2'd2, 1'b0, 32'h040, 32'h11223344, 0, rd, er, ac);
        applyStimulus(1, 1'b0, 2'd2, 1'b0, 32'h040, 32'h0, 4, rd, er, ac);
        checkOutput("ws3_word40", rd, 32'h11223344);

        // Reset during WAIT aborts the store
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_size[1]  = 2'd2;
        req_signed[1] = 1'b0;
        req_addr[1]  = 32'h040;
        req_wdata[1] = 32'hCAFEF00D;
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        exp_pending[1] = 1'b1;
        req_valid[1]   = 1'b0;
        rst_n          = 1'b0;
        @(posedge clk); #1;
        checkReset();
        exp_pending = '0;
        rst_n       = 1'b1;
        applyStimulus(1, 1'b0, 2'd2, 1'b0, 32'h040, 32'h0, 0, rd, er, ac);
        checkOutput("abort_word40", rd, 32'h11223344);

        // Randomised traffic on both instances
        for (int n = 0; n < 300; n++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ad = 32'($urandom_range(0, DEPTH + 8));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) ad = ad & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 15) == 0) ad = ad | (32'd1 << $urandom_range(9, 31));
            applyStimulus(n % 2, 1'($urandom), sz, 1'($urandom), ad, $urandom,
                          $urandom_range(0, 2), rd, er, ac);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
